spi_frame_receiver: RTL and testbench



---
 rtl/spi_frame_pkg.sv | 18 +
 rtl/spi_word_shifter.sv | 42 ++++
 rtl/spi_frame_receiver.sv | 165 ++++++++++++++++
 tb/tb_spi_frame_receiver.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/spi_frame_pkg.sv
// Shared types and default geometry for the framed SPI receiver.
// Optional trailing checksum word is enabled by SPI_RX_CHECKSUM_EN.
package spi_frame_pkg;

  localparam int          DEF_WORD_W = 16;
  localparam int          DEF_ADDR_W = 12;
  localparam int          DEF_LEN_W  = 12;
  localparam logic [15:0] DEF_SYNC   = 16'hA55A;

  typedef enum logic [2:0] {
    HUNT,
    HDR_ADDR,
    HDR_LEN,
    DATA,
    CSUM
  } state_t;

endpackage

// File: rtl/spi_word_shifter.sv
// MSB-first deserialiser: shift register plus bit counter; align holds the counter at 0.
// word is combinational on the live mosi bit; word_valid is high on the final-bit edge.
module spi_word_shifter #(
  parameter int WORD_W = 16
) (
  input  logic              spi_clk,
  input  logic              reset,
  input  logic              spi_mosi,
  input  logic              align,
  output logic [WORD_W-1:0] word,
  output logic              word_valid
);

  localparam int              CNT_W    = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);

  // Only the previous WORD_W-1 bits are ever needed; the live bit completes the word.
  logic [WORD_W-2:0] sr_q, sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    sr_d  = {sr_q[WORD_W-3:0], spi_mosi};
    cnt_d = cnt_q + CNT_W'(1);
    if (align || (cnt_q == CNT_LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge spi_clk or posedge reset) begin
    if (reset) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign word       = {sr_q, spi_mosi};
  assign word_valid = !align && (cnt_q == CNT_LAST);

endmodule

// File: rtl/spi_frame_receiver.sv
// Framed SPI slave: hunts for SYNC, parses addr/len header, emits one write strobe per data word.
// Writes appear on the final-bit edge of each word, no backpressure; SPI_RX_CHECKSUM_EN adds a checksum word.
module spi_frame_receiver
  import spi_frame_pkg::*;
#(
  parameter int                WORD_W = DEF_WORD_W,
  parameter int                ADDR_W = DEF_ADDR_W,
  parameter int                LEN_W  = DEF_LEN_W,
  parameter logic [WORD_W-1:0] SYNC   = WORD_W'(DEF_SYNC)
) (
  input  logic              spi_clk,
  input  logic              reset,
  input  logic              spi_mosi,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              frame_done,
  output logic              frame_err,
  output logic              busy
);

  // One extra bit so a length field of all-ones still counts 2^LEN_W words.
  localparam int REM_W = LEN_W + 1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [WORD_W-1:0] wr_data_q, wr_data_d;
  logic              done_q, done_d;
`ifdef SPI_RX_CHECKSUM_EN
  logic [WORD_W-1:0] csum_q, csum_d;
  logic              err_q, err_d;
`endif

  logic [WORD_W-1:0] word;
  logic              word_valid;
  logic              align;

  assign align = (state_q == HUNT);

  spi_word_shifter #(
    .WORD_W(WORD_W)
  ) u_shifter (
    .spi_clk   (spi_clk),
    .reset     (reset),
    .spi_mosi  (spi_mosi),
    .align     (align),
    .word      (word),
    .word_valid(word_valid)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
`ifdef SPI_RX_CHECKSUM_EN
    csum_d    = csum_q;
    err_d     = 1'b0;
`endif
    unique case (state_q)
      HUNT: begin
        if (word == SYNC) begin
          state_d = HDR_ADDR;
`ifdef SPI_RX_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      HDR_ADDR: begin
        if (word_valid) begin
          addr_d  = word[ADDR_W-1:0];
          state_d = HDR_LEN;
`ifdef SPI_RX_CHECKSUM_EN
          csum_d  = csum_q + word;
`endif
        end
      end
      HDR_LEN: begin
        if (word_valid) begin
          rem_d   = REM_W'(word[LEN_W-1:0]) + REM_W'(1);
          state_d = DATA;
`ifdef SPI_RX_CHECKSUM_EN
          csum_d  = csum_q + word;
`endif
        end
      end
      DATA: begin
        if (word_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = word;
          addr_d    = addr_q + ADDR_W'(1);
          rem_d     = rem_q - REM_W'(1);
`ifdef SPI_RX_CHECKSUM_EN
          csum_d    = csum_q + word;
          if (rem_q == REM_W'(1)) begin
            state_d = CSUM;
          end
`else
          if (rem_q == REM_W'(1)) begin
            state_d = HUNT;
            done_d  = 1'b1;
          end
`endif
        end
      end
`ifdef SPI_RX_CHECKSUM_EN
      CSUM: begin
        if (word_valid) begin
          state_d = HUNT;
          done_d  = 1'b1;
          err_d   = (word != csum_q);
        end
      end
`endif
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge spi_clk or posedge reset) begin
    if (reset) begin
      state_q   <= HUNT;
      addr_q    <= '0;
      rem_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
`ifdef SPI_RX_CHECKSUM_EN
      csum_q    <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
`ifdef SPI_RX_CHECKSUM_EN
      csum_q    <= csum_d;
      err_q     <= err_d;
`endif
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign frame_done = done_q;
  assign busy       = (state_q != HUNT);
`ifdef SPI_RX_CHECKSUM_EN
  assign frame_err  = err_q;
`else
  assign frame_err  = 1'b0;
`endif

endmodule

// File: tb/tb_spi_frame_receiver.sv
// Scoreboard bench for spi_frame_receiver (default geometry); follows SPI_RX_CHECKSUM_EN when defined.
module tb_spi_frame_receiver;

  logic        spi_clk = 1'b0;
  logic        reset;
  logic        spi_mosi;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [15:0] wr_data;
  logic        frame_done;
  logic        frame_err;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [11:0] a;
    logic [15:0] d;
    logic        last;
  } wr_t;

  wr_t         wr_q[$];
  logic        done_q[$];
  logic [15:0] pl[$];

  spi_frame_receiver dut (
    .spi_clk   (spi_clk),
    .reset     (reset),
    .spi_mosi  (spi_mosi),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .frame_done(frame_done),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 spi_clk = ~spi_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Outputs change on posedge; sample them on the falling edge.
  always @(negedge spi_clk) begin : mon
    wr_t  e;
    logic ex;
    if (!reset) begin
      if (wr_en) begin
        if (wr_q.size() == 0) begin
          check("wr_unexpected", wr_en, 1'b0);
        end else begin
          e = wr_q.pop_front();
          check("wr_addr", wr_addr, e.a);
          check("wr_data", wr_data, e.d);
`ifndef SPI_RX_CHECKSUM_EN
          check("done_with_last", frame_done, e.last);
`endif
        end
      end
      if (frame_done) begin
        if (done_q.size() == 0) begin
          check("done_unexpected", frame_done, 1'b0);
        end else begin
          ex = done_q.pop_front();
          check("frame_err", frame_err, ex);
        end
      end else if (frame_err) begin
        check("err_without_done", frame_err, 1'b0);
      end
    end
  end

  task automatic send_bit(input logic b);
    @(negedge spi_clk);
    spi_mosi = b;
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b0);
  endtask

  // Sends sync + header + pl[] (+ checksum); pushes expected writes/completions.
  task automatic send_frame(input logic [15:0] aw, input logic [15:0] lw, input logic bad_csum);
    logic [15:0] sum;
    logic [11:0] a;
    int          n;
    n   = pl.size();
    sum = aw + lw;
    a   = aw[11:0];
    send_word(16'hA55A);
    send_word(aw);
    check("busy_in_frame", busy, 1'b1);
    send_word(lw);
    for (int i = 0; i < n; i++) begin
      wr_q.push_back('{a: a, d: pl[i], last: (i == n - 1)});
`ifndef SPI_RX_CHECKSUM_EN
      if (i == n - 1) done_q.push_back(1'b0);
`endif
      send_word(pl[i]);
      sum = sum + pl[i];
      a   = a + 12'd1;
    end
`ifdef SPI_RX_CHECKSUM_EN
    done_q.push_back(bad_csum);
    send_word(bad_csum ? sum + 16'd1 : sum);
`endif
    idle(1);
    check("busy_after_frame", busy, 1'b0);
    idle(19);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_wr_en"}, wr_en, 1'b0);
    check({tag, "_wr_addr"}, wr_addr, 12'h000);
    check({tag, "_wr_data"}, wr_data, 16'h0000);
    check({tag, "_done"}, frame_done, 1'b0);
    check({tag, "_err"}, frame_err, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    reset    = 1'b1;
    spi_mosi = 1'b0;
    #12;
    check_outputs_zero("reset");
    @(negedge spi_clk);
    reset = 1'b0;

    // Basic three-word frame sent right after reset.
    pl = '{16'h1234, 16'hABCD, 16'h0F0F};
    send_frame(16'h0010, 16'h0002, 1'b0);

    // Misaligned garbage, then a single-word frame (len 0).
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    pl = '{16'hBEEF};
    send_frame(16'h03FF, 16'h0000, 1'b0);

    // Address wrap, with ignored upper header bits set.
    pl = '{16'h5555, 16'h6666};
    send_frame(16'hFFFF, 16'hF001, 1'b0);

    // Sync pattern as payload, then a normal frame.
    pl = '{16'hA55A, 16'h0001};
    send_frame(16'h0200, 16'h0001, 1'b0);
    pl = '{16'h0042};
    send_frame(16'h0300, 16'h0000, 1'b0);

    // Reset after 7 bits of the second data word.
    send_word(16'hA55A);
    send_word(16'h0100);
    send_word(16'h0002);
    wr_q.push_back('{a: 12'h100, d: 16'h1111, last: 1'b0});
    send_word(16'h1111);
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    @(negedge spi_clk);
    reset = 1'b1;
    #1;
    check_outputs_zero("midreset");
    @(negedge spi_clk);
    @(negedge spi_clk);
    reset = 1'b0;
    idle(20);
    check("midreset_no_write", wr_en, 1'b0);
    pl = '{16'h0777};
    send_frame(16'h0020, 16'h0000, 1'b0);

`ifdef SPI_RX_CHECKSUM_EN
    pl = '{16'h0002};
    send_frame(16'h0001, 16'h0000, 1'b0);
    pl = '{16'h0002};
    send_frame(16'h0001, 16'h0000, 1'b1);
`endif

    idle(5);
    check("sb_writes_left", wr_q.size(), 0);
    check("sb_done_left", done_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
